// File: rtl/pixel_event_readout_ctrl.sv
// Event readout controller: buffers encoded pixel events in a small FIFO and
// drains them over a valid/ready stream, closing each arbitration group with a last beat.
module pixel_event_readout_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AFULL_TH = 6,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     evt_valid_i,
    input  logic [DATA_W-1:0]        evt_data_i,
    input  logic                     grp_release_i,
    output logic                     hold_o,
    output logic                     m_valid_o,
    output logic [DATA_W-1:0]        m_data_o,
    output logic                     m_last_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [CNT_W-1:0]         grp_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_grp_inc;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_rel_q;
    logic              r_rel_q2;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  r_grp_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_write;
    logic              w_drop;
    logic              w_valid;
    logic              w_pop;
    logic              w_rel_rise;
    logic              w_last_beat;

    // Full is decoded from the registered level, so a same-cycle pop never frees a slot for the write
    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_empty     = (r_level == LVL_W'(0));
    assign w_write     = evt_valid_i && (r_state != FLUSH) && !w_full;
    assign w_drop      = evt_valid_i && !w_write;
    assign w_valid     = (r_state != IDLE) && !w_empty;
    assign w_pop       = w_valid && m_ready_i;
    assign w_rel_rise  = r_rel_q && !r_rel_q2;
    assign w_last_beat = (r_state == FLUSH) && (r_level == LVL_W'(1));

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and group-completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_grp_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rel_rise && w_empty) begin
                    w_grp_inc = 1'b1;
                end
                // Leave on the write itself so the new event is visible right after its edge
                if (!w_empty || w_write) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_rel_rise) begin
                    w_state_nxt = FLUSH;
                end else if (w_empty && !w_write) begin
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (w_empty || (w_pop && w_last_beat)) begin
                    w_state_nxt = IDLE;
                    w_grp_inc   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset since reads are masked by the level
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_wptr] <= evt_data_i;
        end
    end

    // Pointers, level, release edge detect and statistics
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_rel_q    <= 1'b0;
            r_rel_q2   <= 1'b0;
            r_drop_cnt <= '0;
            r_grp_cnt  <= '0;
        end else begin
            r_rel_q  <= grp_release_i;
            r_rel_q2 <= r_rel_q;
            if (w_write) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (w_grp_inc) begin
                r_grp_cnt <= r_grp_cnt + CNT_W'(1);
            end
        end
    end

    assign hold_o       = (r_state == FLUSH) || (r_level >= LVL_W'(AFULL_TH));
    assign m_valid_o    = w_valid;
    assign m_data_o     = w_valid ? r_mem[r_rptr] : '0;
    assign m_last_o     = w_valid && w_last_beat;
    assign fifo_level_o = r_level;
    assign drop_cnt_o   = r_drop_cnt;
    assign grp_cnt_o    = r_grp_cnt;

endmodule

// File: tb/tb_pixel_event_readout_ctrl.sv
// Directed self-checking bench for pixel_event_readout_ctrl (DEPTH=8, AFULL_TH=6).
module tb_pixel_event_readout_ctrl;

    logic        clk;
    logic        reset;
    logic        evt_valid;
    logic [31:0] evt_data;
    logic        grp_release;
    logic        hold;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic [3:0]  fifo_level;
    logic [15:0] drop_cnt;
    logic [15:0] grp_cnt;

    int          n_checks;
    int          n_fail;
    logic [31:0] beat_q [$];
    logic        last_q [$];

    pixel_event_readout_ctrl #(
        .DATA_W   (32),
        .DEPTH    (8),
        .AFULL_TH (6),
        .CNT_W    (16)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .evt_valid_i   (evt_valid),
        .evt_data_i    (evt_data),
        .grp_release_i (grp_release),
        .hold_o        (hold),
        .m_valid_o     (m_valid),
        .m_data_o      (m_data),
        .m_last_o      (m_last),
        .m_ready_i     (m_ready),
        .fifo_level_o  (fifo_level),
        .drop_cnt_o    (drop_cnt),
        .grp_cnt_o     (grp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat in order
    always @(posedge clk) begin
        if (!reset && m_valid && m_ready) begin
            beat_q.push_back(m_data);
            last_q.push_back(m_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        evt_valid   = 1'b0;
        evt_data    = '0;
        grp_release = 1'b0;
        m_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic write_evt(input logic [31:0] d);
        evt_valid = 1'b1;
        evt_data  = d;
        step();
        evt_valid = 1'b0;
    endtask

    initial begin
        int   base;
        logic hold_or;
        n_checks = 0;
        n_fail   = 0;

        // Reset values
        reset       = 1'b1;
        evt_valid   = 1'b0;
        evt_data    = '0;
        grp_release = 1'b0;
        m_ready     = 1'b0;
        @(negedge clk);
        chk("rst_hold",  32'(hold), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last",  32'(m_last), 0);
        chk("rst_data",  m_data, 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_drop",  32'(drop_cnt), 0);
        chk("rst_grp",   32'(grp_cnt), 0);
        do_reset();

        // Single event with downstream ready
        base    = beat_q.size();
        m_ready = 1'b1;
        evt_valid = 1'b1;
        evt_data  = 32'h1234_5678;
        step();
        evt_valid = 1'b0;
        chk("single_visible", 32'(m_valid), 1);
        chk("single_vis_data", m_data, 32'h1234_5678);
        repeat (4) step();
        chk("single_count", 32'(beat_q.size() - base), 1);
        chk("single_data",  beat_q[base], 32'h1234_5678);
        chk("single_last",  32'(last_q[base]), 0);
        chk("single_level", 32'(fifo_level), 0);
        chk("single_state", 32'(dut.r_state), 0);

        // Fill past full with the sink stalled, then drain
        do_reset();
        for (int i = 0; i < 10; i++) begin
            evt_valid = 1'b1;
            evt_data  = 32'h0000_00A0 + 32'(i);
            step();
            if (i == 4) chk("fill_hold_5", 32'(hold), 0);
            if (i == 5) chk("fill_hold_6", 32'(hold), 1);
        end
        evt_valid = 1'b0;
        chk("fill_level", 32'(fifo_level), 8);
        chk("fill_drop",  32'(drop_cnt), 2);
        chk("fill_hold",  32'(hold), 1);
        base    = beat_q.size();
        m_ready = 1'b1;
        repeat (10) step();
        chk("fill_count", 32'(beat_q.size() - base), 8);
        for (int i = 0; i < 8; i++) begin
            chk("fill_order", beat_q[base+i], 32'h0000_00A0 + 32'(i));
            chk("fill_last",  32'(last_q[base+i]), 0);
        end
        chk("fill_level_end", 32'(fifo_level), 0);

        // Group flush of three buffered events
        do_reset();
        write_evt(32'h0000_00B0);
        write_evt(32'h0000_00B1);
        write_evt(32'h0000_00B2);
        base        = beat_q.size();
        grp_release = 1'b1;
        m_ready     = 1'b1;
        step();
        step();
        evt_valid = 1'b1;
        evt_data  = 32'h0000_DEAD;
        chk("flush_hold",  32'(hold), 1);
        chk("flush_valid", 32'(m_valid), 1);
        chk("flush_lastb", 32'(m_last), 1);
        step();
        evt_valid   = 1'b0;
        grp_release = 1'b0;
        chk("flush_hold_off", 32'(hold), 0);
        repeat (3) step();
        chk("flush_count", 32'(beat_q.size() - base), 3);
        for (int i = 0; i < 3; i++) begin
            chk("flush_data", beat_q[base+i], 32'h0000_00B0 + 32'(i));
            chk("flush_last", 32'(last_q[base+i]), (i == 2) ? 32'd1 : 32'd0);
        end
        chk("flush_grp",  32'(grp_cnt), 1);
        chk("flush_drop", 32'(drop_cnt), 1);

        // Empty group
        do_reset();
        base        = beat_q.size();
        hold_or     = 1'b0;
        m_ready     = 1'b1;
        grp_release = 1'b1;
        repeat (5) begin
            step();
            hold_or = hold_or | hold;
        end
        grp_release = 1'b0;
        step();
        hold_or = hold_or | hold;
        chk("empty_grp",   32'(grp_cnt), 1);
        chk("empty_beats", 32'(beat_q.size() - base), 0);
        chk("empty_hold",  32'(hold_or), 0);

        // Stall stability with two events buffered
        do_reset();
        write_evt(32'h0000_0011);
        write_evt(32'h0000_0022);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data",  m_data, 32'h0000_0011);
        end
        base    = beat_q.size();
        m_ready = 1'b1;
        repeat (4) step();
        chk("stall_count", 32'(beat_q.size() - base), 2);
        chk("stall_d0",    beat_q[base], 32'h0000_0011);
        chk("stall_d1",    beat_q[base+1], 32'h0000_0022);

        // Asynchronous reset in the middle of a flush
        do_reset();
        for (int i = 0; i < 5; i++) write_evt(32'h0000_00C0 + 32'(i));
        grp_release = 1'b1;
        step();
        step();
        chk("mid_hold",  32'(hold), 1);
        chk("mid_level", 32'(fifo_level), 5);
        chk("mid_state", 32'(dut.r_state), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_hold",  32'(hold), 0);
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_last",  32'(m_last), 0);
        chk("mid_rst_data",  m_data, 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_drop",  32'(drop_cnt), 0);
        chk("mid_rst_grp",   32'(grp_cnt), 0);
        grp_release = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("mid_post_state", 32'(dut.r_state), 0);
        chk("mid_post_level", 32'(fifo_level), 0);
        chk("mid_post_valid", 32'(m_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pixel_event_readout_ctrl.md
# pixel_event_readout_ctrl

Readout controller between the pixel hierarchy's event encoder and the off-chip event link. It buffers encoded events (row, column, timestamp, polarity) in a small FIFO and drains them over a valid/ready stream. It applies backpressure to the arbitration hierarchy when near full and delimits each arbitration group with an end-of-group beat. It also keeps drop and group statistics for debug.

## Interface
Parameters:
- DATA_W, 32: width of one encoded event word (matches the encoder's data_out_o width).
- DEPTH, 8: FIFO entries; power of two, at least 4.
- AFULL_TH, 6: fill level at or above which hold_o asserts; must be less than DEPTH.
- CNT_W, 16: width of the statistics counters.

Ports (one clock; reset is asynchronous and active-high):
- clk_i, input, 1: clock; all state updates on the rising edge.
- reset_i, input, 1: asynchronous active-high reset.
- evt_valid_i, input, 1: event word present this cycle (the hierarchy's overall active signal).
- evt_data_i, input, DATA_W: encoded event word.
- grp_release_i, input, 1: the hierarchy's top-level group release (all active requests granted).
- hold_o, output, 1: backpressure to the hierarchy; while high, the hierarchy suspends granting.
- m_valid_o, output, 1: output beat valid.
- m_data_o, output, DATA_W: output beat data (the FIFO head).
- m_last_o, output, 1: the current beat is the final event of a group.
- m_ready_i, input, 1: downstream accepts the beat.
- fifo_level_o, output, $clog2(DEPTH)+1: current FIFO occupancy.
- drop_cnt_o, output, CNT_W: events refused; saturates at all-ones.
- grp_cnt_o, output, CNT_W: groups completed; wraps modulo 2^CNT_W.

## Operation
- FIFO storage:
  - DEPTH x DATA_W, with read and write pointers and a level register.
  - full means level == DEPTH; empty means level == 0.
- Write acceptance:
  - A write happens when evt_valid_i=1, state != FLUSH, and the *registered* full flag is 0.
  - A same-cycle pop does not free a slot for that cycle's write.
- Drops: an event that is not accepted increments drop_cnt_o by 1, saturating.
- Pop: a pop happens when m_valid_o && m_ready_i.
- Level update: level increments on a write only, decrements on a pop only, and is unchanged when both occur.
- Group release detection: grp_release_i is registered; its rising edge (rel_rise) is the group event.
- State machine, states IDLE, STREAM, FLUSH:
  - IDLE: m_valid_o=0.
    - Level > 0 -> STREAM.
    - rel_rise with the FIFO empty -> stay in IDLE and increment grp_cnt_o (empty group, no last beat).
  - STREAM: m_valid_o = !empty; m_last_o=0.
    - rel_rise -> FLUSH.
    - Empty with no rel_rise -> IDLE.
  - FLUSH: writes are blocked, and any evt_valid_i counts as a drop.
    - m_valid_o = !empty.
    - m_last_o = (level == 1).
    - When the last beat is popped -> IDLE and increment grp_cnt_o.
    - If FLUSH is entered with the FIFO already empty (a pop in the same cycle as rel_rise), go directly to IDLE, increment grp_cnt_o, and emit no last beat.
- hold_o = (state == FLUSH) || (level >= AFULL_TH).
- Downstream stall: m_data_o, m_last_o and m_valid_o hold stable while m_valid_o=1 and m_ready_i=0.
- Reset, including mid-operation:
  - State returns to IDLE; pointers, level and counters clear; the FIFO contents are discarded.
  - Outputs are all 0: hold_o, m_valid_o, m_last_o, fifo_level_o, drop_cnt_o, grp_cnt_o, and m_data_o.

## Timing
- Write to visible: an event written at edge N is visible on m_valid_o/m_data_o after edge N (so it can pop at edge N+1).
- Throughput: 1 event per cycle sustained, with simultaneous write and pop.
- Backpressure: hold_o rises in the cycle after the level reaches AFULL_TH.
  - It is decoded only from registered state, so it is glitch-free.
  - The hierarchy may still deliver up to DEPTH-AFULL_TH in-flight events without loss.
- Group release: rel_rise is seen one cycle after grp_release_i rises, and FLUSH is entered on the following edge.
- End of group: m_last_o is asserted together with m_valid_o on the final beat only.

## Test plan
- Single event: after reset, pulse evt_valid_i with data 0x12345678 while m_ready_i=1.
  - Expect one beat with data 0x12345678, m_last_o=0, fifo_level_o back to 0, and state back in IDLE.
- Fill and drop: with DEPTH=8 and AFULL_TH=6, hold m_ready_i=0 and drive 10 consecutive events.
  - Expect hold_o high from the cycle after the 6th write, level 8, and drop_cnt_o=2.
  - Then release m_ready_i and expect 8 beats in write order.
- Group flush: write 3 events, then raise grp_release_i with m_ready_i=1.
  - Expect hold_o high during FLUSH and 3 beats, with m_last_o only on the third.
  - Expect grp_cnt_o=1 and an evt_valid_i sent during FLUSH to count as drop_cnt_o=1.
- Empty group: raise grp_release_i with the FIFO empty.
  - Expect no beats, grp_cnt_o incremented, and hold_o never asserted.
- Stall stability: with 2 events buffered and m_ready_i=0 for 5 cycles, expect m_data_o and m_valid_o unchanged. Then expect ordered delivery.
- Reset mid-operation: assert reset_i with 5 events buffered during FLUSH.
  - Expect all outputs 0 immediately, and on release state IDLE and level 0.
